// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and 8N1 frame constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Last data bit index for the 3-bit bit-index registers.
  localparam logic [2:0] LAST_DATA_IDX = 3'(DATA_BITS - 1);

  // Common 3-bit encoding used by both the TX and RX state machines.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, with a selectable strobe.
// Latency: strobe is a registered-count compare, asserted in the cycle the count hits its target.
// Backpressure: none; clr_i holds the count at zero.
//
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : synchronous clear to 0
//   half_i        : 1 -> strobe at the mid-bit count, 0 -> strobe at the last count of the bit
//   strobe_o      : one-cycle strobe at the selected count
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic half_i,
  output logic strobe_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_full;

  assign at_full  = (cnt_q == FULL_CNT);
  assign strobe_o = half_i ? (cnt_q == HALF_CNT) : at_full;

  // Wrap only on the last count of a bit, so the counter never overflows mid-bit.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || at_full) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_tx.sv
// Full-duplex 8N1 UART: independent TX and RX state machines sharing one clock.
// Latency: TX line starts the start bit one cycle after i_TX_DV; o_RX_DV rises mid stop bit.
// Backpressure: none; i_TX_DV outside IDLE is dropped, RX has no hold-off.
//
// Ports:
//   i_Clock, i_Reset_n              : clock, async active-low reset
//   i_TX_DV, i_TX_Byte              : one-cycle transmit request and its byte
//   o_TX_Active, o_TX_Serial        : line ownership (start..stop) and serial TX line
//   o_TX_Done                       : one-cycle pulse at the end of the stop bit
//   i_RX_Serial                     : asynchronous serial RX line
//   o_RX_DV, o_RX_Byte              : received-byte pulse and last good byte
module uart_rx_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte
);

  // ---------------------------------------------------------------- TX path
  uart_state_e tx_state_q, tx_state_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic        tx_active_q, tx_active_d;
  logic        tx_done_q, tx_done_d;
  logic        tx_serial_q, tx_serial_d;
  logic        tx_clr, tx_tick;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk_i    (i_Clock),
    .rst_ni   (i_Reset_n),
    .clr_i    (tx_clr),
    .half_i   (1'b0),
    .strobe_o (tx_tick)
  );

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_byte_d   = tx_byte_q;
    tx_idx_d    = tx_idx_q;
    tx_active_d = tx_active_q;
    tx_done_d   = 1'b0;
    tx_clr      = 1'b0;
    unique case (tx_state_q)
      ST_IDLE: begin
        // Hold the timer at zero so START gets a full bit period.
        tx_clr = 1'b1;
        if (i_TX_DV) begin
          tx_byte_d   = i_TX_Byte;
          tx_active_d = 1'b1;
          tx_state_d  = ST_START;
        end
      end
      ST_START: begin
        if (tx_tick) begin
          tx_idx_d   = '0;
          tx_state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_tick) begin
          if (tx_idx_q == LAST_DATA_IDX) begin
            tx_state_d = ST_STOP;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (tx_tick) begin
          tx_done_d   = 1'b1;
          tx_active_d = 1'b0;
          tx_state_d  = ST_CLEANUP;
        end
      end
      ST_CLEANUP: begin
        tx_clr     = 1'b1;
        tx_state_d = ST_IDLE;
      end
      default: begin
        tx_clr     = 1'b1;
        tx_state_d = ST_IDLE;
      end
    endcase

    // Line level is registered from the next state so it changes on the same edge as the state.
    unique case (tx_state_d)
      ST_START: tx_serial_d = 1'b0;
      ST_DATA:  tx_serial_d = tx_byte_d[tx_idx_d];
      default:  tx_serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      tx_state_q  <= ST_IDLE;
      tx_byte_q   <= '0;
      tx_idx_q    <= '0;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_serial_q <= 1'b1;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_byte_q   <= tx_byte_d;
      tx_idx_q    <= tx_idx_d;
      tx_active_q <= tx_active_d;
      tx_done_q   <= tx_done_d;
      tx_serial_q <= tx_serial_d;
    end
  end

  assign o_TX_Active = tx_active_q;
  assign o_TX_Serial = tx_serial_q;
  assign o_TX_Done   = tx_done_q;

  // ---------------------------------------------------------------- RX path
  logic        rx_meta_q, rx_sync_q;
  uart_state_e rx_state_q, rx_state_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic        rx_dv_q, rx_dv_d;
  logic        rx_clr, rx_half, rx_tick;

  // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_RX_Serial;
      rx_sync_q <= rx_meta_q;
    end
  end

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk_i    (i_Clock),
    .rst_ni   (i_Reset_n),
    .clr_i    (rx_clr),
    .half_i   (rx_half),
    .strobe_o (rx_tick)
  );

  // Only the start-bit check uses the half-bit strobe; after it the timer is
  // re-zeroed so every later full-bit strobe lands mid-bit.
  assign rx_half = (rx_state_q == ST_START);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_idx_d   = rx_idx_q;
    rx_dv_d    = 1'b0;
    rx_clr     = 1'b0;
    unique case (rx_state_q)
      ST_IDLE: begin
        rx_clr = 1'b1;
        if (!rx_sync_q) begin
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (rx_tick) begin
          rx_clr = 1'b1;
          if (!rx_sync_q) begin
            rx_idx_d   = '0;
            rx_state_d = ST_DATA;
          end else begin
            rx_state_d = ST_IDLE;   // glitch, not a real start bit
          end
        end
      end
      ST_DATA: begin
        if (rx_tick) begin
          rx_shift_d[rx_idx_q] = rx_sync_q;
          if (rx_idx_q == LAST_DATA_IDX) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (rx_tick) begin
          // A low stop bit is a framing error: drop the byte silently.
          if (rx_sync_q) begin
            rx_byte_d = rx_shift_q;
            rx_dv_d   = 1'b1;
          end
          rx_state_d = ST_CLEANUP;
        end
      end
      ST_CLEANUP: begin
        rx_clr     = 1'b1;
        rx_state_d = ST_IDLE;
      end
      default: begin
        rx_clr     = 1'b1;
        rx_state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      rx_state_q <= ST_IDLE;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_idx_q   <= '0;
      rx_dv_q    <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_idx_q   <= rx_idx_d;
      rx_dv_q    <= rx_dv_d;
    end
  end

  assign o_RX_DV   = rx_dv_q;
  assign o_RX_Byte = rx_byte_q;

endmodule

// File: tb/tb_uart_rx_tx.sv
// Self-checking bench for uart_rx_tx: loopback, TX waveform, busy drop, RX glitch/framing, reset, back-to-back.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_tx;

  localparam int C = 217;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active, tx_serial, tx_done;
  logic       rx_serial;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       loop_en;
  logic       drv_line;

  always #5 clk = ~clk;

  assign rx_serial = loop_en ? (tx_active ? tx_serial : 1'b1) : drv_line;

  uart_rx_tx #(.CLKS_PER_BIT(C)) dut (
    .i_Clock     (clk),
    .i_Reset_n   (rst_n),
    .i_TX_DV     (tx_dv),
    .i_TX_Byte   (tx_byte),
    .o_TX_Active (tx_active),
    .o_TX_Serial (tx_serial),
    .o_TX_Done   (tx_done),
    .i_RX_Serial (rx_serial),
    .o_RX_DV     (rx_dv),
    .o_RX_Byte   (rx_byte)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Passive monitor: log every received byte and count done pulses / active cycles.
  logic [7:0] rx_log[$];
  int         done_total = 0;
  int         act_total  = 0;

  always @(negedge clk) begin
    if (rx_dv) rx_log.push_back(rx_byte);
    if (tx_done) done_total++;
    if (tx_active) act_total++;
  end

  // Reference for o_RX_Byte: last byte accepted with a good stop bit (0 after reset).
  logic [7:0] last_good;

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    tx_byte = b;
    tx_dv   = 1'b1;
    @(posedge clk); #1;
    tx_dv   = 1'b0;
  endtask

  task automatic wait_done(input int base);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 12 * C && !seen; k++) begin
      @(negedge clk);
      if (done_total > base) seen = 1'b1;
    end
    check("tx_done_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // One frame on the looped-back line; optionally checks the TX waveform cycle by cycle.
  task automatic loop_frame(input logic [7:0] b, input bit chk_wave);
    int         rx0, d0, a0, bad, len;
    bit         found;
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    rx0   = rx_log.size();
    d0    = done_total;
    a0    = act_total;
    bad   = 0;
    found = 1'b0;
    send(b);
    if (chk_wave) begin
      for (int k = 0; k < 3 && !found; k++) begin
        @(negedge clk);
        if (tx_serial == 1'b0) found = 1'b1;
      end
      check("tx_start_latency", 32'(found), 32'd1);
      if (found) begin
        for (int j = 0; j < 10 * C; j++) begin
          if (j > 0) @(negedge clk);
          if (tx_serial !== frame[j / C]) bad++;
        end
        check("tx_wave_bad_cycles", 32'(bad), 32'd0);
      end
    end
    wait_done(d0);
    check("tx_idle_line", 32'(tx_serial), 32'd1);
    check("tx_done_count", 32'(done_total - d0), 32'd1);
    len = act_total - a0;
    check("tx_active_len_ok", 32'(len >= 10 * C - 2 && len <= 10 * C + 2), 32'd1);
    check("rx_dv_count", 32'(rx_log.size() - rx0), 32'd1);
    if (rx_log.size() > rx0) check("rx_byte_loop", 32'(rx_log[rx0]), 32'(b));
    last_good = b;
    check("rx_byte_hold", 32'(rx_byte), 32'(last_good));
  endtask

  // Drive an 8N1 frame directly onto the RX input with a chosen stop-bit level.
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      drv_line = frame[i];
      repeat (C) @(posedge clk);
      #1;
    end
    drv_line = 1'b1;
  endtask

  initial begin
    int         rx0, d0;
    logic [7:0] b;

    rst_n     = 1'b0;
    tx_dv     = 1'b0;
    tx_byte   = 8'h00;
    loop_en   = 1'b1;
    drv_line  = 1'b1;
    last_good = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx_serial", 32'(tx_serial), 32'd1);
    check("rst_tx_active", 32'(tx_active), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_rx_dv", 32'(rx_dv), 32'd0);
    check("rst_rx_byte", 32'(rx_byte), 32'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Loopback of 0x3F, then exact TX bit timing of 0xA5 and random bytes
    loop_frame(8'h3F, 1'b0);
    loop_frame(8'hA5, 1'b1);
    for (int n = 0; n < 4; n++) loop_frame(8'($urandom), 1'b1);

    // Request while busy is dropped
    rx0 = rx_log.size();
    d0  = done_total;
    send(8'hFF);
    repeat (3 * C) @(posedge clk);
    send(8'h00);
    wait_done(d0);
    repeat (12 * C) @(negedge clk);
    check("busy_done_count", 32'(done_total - d0), 32'd1);
    check("busy_rx_count", 32'(rx_log.size() - rx0), 32'd1);
    if (rx_log.size() > rx0) check("busy_rx_byte", 32'(rx_log[rx0]), 32'hFF);
    last_good = 8'hFF;

    // RX glitch: 50-clock low pulse
    loop_en = 1'b0;
    rx0 = rx_log.size();
    @(posedge clk); #1;
    drv_line = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    drv_line = 1'b1;
    repeat (3 * C) @(negedge clk);
    check("glitch_no_dv", 32'(rx_log.size() - rx0), 32'd0);

    // Framing error: stop bit low
    rx0 = rx_log.size();
    drive_frame(8'h5A, 1'b0);
    repeat (12 * C) @(negedge clk);
    check("frame_err_no_dv", 32'(rx_log.size() - rx0), 32'd0);
    check("frame_err_hold", 32'(rx_byte), 32'(last_good));

    // RX still works on a random well-formed frame afterwards
    rx0 = rx_log.size();
    b   = 8'($urandom);
    drive_frame(b, 1'b1);
    repeat (C) @(negedge clk);
    check("drive_rx_count", 32'(rx_log.size() - rx0), 32'd1);
    if (rx_log.size() > rx0) check("drive_rx_byte", 32'(rx_log[rx0]), 32'(b));
    last_good = b;

    // Reset in the middle of data bit 4
    loop_en = 1'b1;
    rx0 = rx_log.size();
    d0  = done_total;
    send(8'($urandom));
    repeat (5 * C + C / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_tx_serial", 32'(tx_serial), 32'd1);
    check("midrst_tx_active", 32'(tx_active), 32'd0);
    check("midrst_rx_byte", 32'(rx_byte), 32'h00);
    last_good = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12 * C) @(negedge clk);
    check("midrst_no_dv", 32'(rx_log.size() - rx0), 32'd0);
    check("midrst_no_done", 32'(done_total - d0), 32'd0);

    // Back-to-back frames 0x00 then 0xFF
    rx0 = rx_log.size();
    d0  = done_total;
    send(8'h00);
    wait_done(d0);
    send(8'hFF);
    wait_done(d0 + 1);
    check("b2b_rx_count", 32'(rx_log.size() - rx0), 32'd2);
    if (rx_log.size() > rx0 + 1) begin
      check("b2b_byte0", 32'(rx_log[rx0]), 32'h00);
      check("b2b_byte1", 32'(rx_log[rx0 + 1]), 32'hFF);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
